// File: rtl/byte_we_ram_pkg.sv
// byte_we_ram shared constants and FSM state type.
// Optional output stage: define BYTE_WE_RAM_OUT_REG_EN.
package byte_we_ram_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int BYTE_W    = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/byte_we_ram_array.sv
// byte_we_ram storage: byte-lane writes and a registered read port.
// Out-of-range addresses drop writes and read back zero.
module byte_we_ram_array
  import byte_we_ram_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WE_WIDTH   = WIDTH / BYTE_W,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WE_WIDTH-1:0]   we,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  rvalid,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  assign in_range =
    ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));

  // Storage itself is never reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (we[i]) begin
          mem[addr][i*BYTE_W +: BYTE_W] <=
            wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= in_range ? mem[addr] : '0;
      end
    end
  end

endmodule

// File: rtl/byte_we_ram.sv
// byte_we_ram top: zero sweep FSM, request accept, response path.
// Define BYTE_WE_RAM_OUT_REG_EN for a 2-cycle registered response.
module byte_we_ram
  import byte_we_ram_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WE_WIDTH   = WIDTH / BYTE_W,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WE_WIDTH-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  init_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  acc;
  logic                  wr;
  logic                  rd;

  logic                  a_wr;
  logic [WE_WIDTH-1:0]   a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [WIDTH-1:0]      a_wdata;
  logic                  a_rvalid;
  logic [WIDTH-1:0]      a_rdata;

  assign req_ready = init_done;
  assign acc       = req_valid && init_done;
  assign wr        = acc && (|req_we);
  assign rd        = acc && !(|req_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Sweep and request writes never overlap: ready is low in INIT.
  always_comb begin
    a_wr    = 1'b0;
    a_we    = '0;
    a_addr  = req_addr;
    a_wdata = req_wdata;
    unique case (1'b1)
      (state == INIT): begin
        a_wr    = 1'b1;
        a_we    = '1;
        a_addr  = cnt;
        a_wdata = '0;
      end
      wr: begin
        a_wr = 1'b1;
        a_we = req_we;
      end
      default: ;
    endcase
  end

  byte_we_ram_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .WE_WIDTH   (WE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (a_wr),
    .we     (a_we),
    .rd_en  (rd),
    .addr   (a_addr),
    .wdata  (a_wdata),
    .rvalid (a_rvalid),
    .rdata  (a_rdata)
  );

`ifdef BYTE_WE_RAM_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= a_rvalid;
      if (a_rvalid) begin
        rsp_rdata <= a_rdata;
      end
    end
  end
`else
  assign rsp_valid = a_rvalid;
  assign rsp_rdata = a_rdata;
`endif

endmodule
